// File: rtl/biriscv_div_issue_pkg.sv
// Shared definitions for the divider issue block: instruction match/mask
// constants, FSM encoding, latched request payload and decode helpers.
package biriscv_div_issue_pkg;

    localparam int unsigned XLEN                 = 32;
    localparam int unsigned REG_IDX_W            = 5;
    localparam int unsigned WAIT_TIMEOUT_DEFAULT = 63;

    localparam logic [31:0] INST_DIV_MASK  = 32'hfe00707f;
    localparam logic [31:0] INST_DIV       = 32'h02004033;
    localparam logic [31:0] INST_DIVU      = 32'h02005033;
    localparam logic [31:0] INST_REM       = 32'h02006033;
    localparam logic [31:0] INST_REMU      = 32'h02007033;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]      opcode;
        logic [XLEN-1:0]      pc;
        logic [REG_IDX_W-1:0] rd_idx;
        logic [REG_IDX_W-1:0] ra_idx;
        logic [REG_IDX_W-1:0] rb_idx;
        logic [XLEN-1:0]      ra_operand;
        logic [XLEN-1:0]      rb_operand;
    } div_req_t;

    // True for any of DIV/DIVU/REM/REMU
    function automatic logic is_div_op(input logic [XLEN-1:0] op);
        logic [XLEN-1:0] m;
        m = op & INST_DIV_MASK;
        return (m == INST_DIV) || (m == INST_DIVU) || (m == INST_REM) || (m == INST_REMU);
    endfunction

    // True for the remainder flavours (REM/REMU)
    function automatic logic is_rem_op(input logic [XLEN-1:0] op);
        logic [XLEN-1:0] m;
        m = op & INST_DIV_MASK;
        return (m == INST_REM) || (m == INST_REMU);
    endfunction

endpackage

// File: rtl/biriscv_div_issue.sv
// Divider issue/writeback initiator: accepts one divide request, strobes the
// divider for one cycle, waits for writeback (with watchdog) and holds the
// result until the pipeline takes it. Optional macro DIV_ISSUE_DIVZERO_FAST_EN
// answers divide-by-zero locally without strobing the divider.
module biriscv_div_issue
    import biriscv_div_issue_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = WAIT_TIMEOUT_DEFAULT
)(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [XLEN-1:0]      req_opcode_i,
    input  logic [XLEN-1:0]      req_pc_i,
    input  logic [REG_IDX_W-1:0] req_rd_idx_i,
    input  logic [REG_IDX_W-1:0] req_ra_idx_i,
    input  logic [REG_IDX_W-1:0] req_rb_idx_i,
    input  logic [XLEN-1:0]      req_ra_operand_i,
    input  logic [XLEN-1:0]      req_rb_operand_i,
    input  logic                 flush_i,
    output logic                 div_opcode_valid_o,
    output logic [XLEN-1:0]      div_opcode_opcode_o,
    output logic [XLEN-1:0]      div_opcode_pc_o,
    output logic                 div_opcode_invalid_o,
    output logic [REG_IDX_W-1:0] div_opcode_rd_idx_o,
    output logic [REG_IDX_W-1:0] div_opcode_ra_idx_o,
    output logic [REG_IDX_W-1:0] div_opcode_rb_idx_o,
    output logic [XLEN-1:0]      div_opcode_ra_operand_o,
    output logic [XLEN-1:0]      div_opcode_rb_operand_o,
    input  logic                 div_writeback_valid_i,
    input  logic [XLEN-1:0]      div_writeback_value_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [REG_IDX_W-1:0] resp_rd_idx_o,
    output logic [XLEN-1:0]      resp_pc_o,
    output logic [XLEN-1:0]      resp_value_o,
    output logic                 busy_o,
    output logic [REG_IDX_W-1:0] busy_rd_idx_o,
    output logic                 err_timeout_o
);

    localparam int unsigned CNT_W = $clog2(WAIT_TIMEOUT + 1);

    state_e           state_q, state_d;
    div_req_t         req_q, req_d;
    logic             kill_q, kill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  value_q, value_d;
    logic             ready_q, ready_d;
    logic             issue_q, issue_d;
    logic             resp_valid_q, resp_valid_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic accept;
    logic req_is_div;
    logic fast_zero;
    logic wb_done;
    logic timeout_hit;
    logic killed;

    assign accept      = (state_q == ST_IDLE) && req_valid_i && !flush_i;
    assign req_is_div  = is_div_op(req_opcode_i);
    assign wb_done     = (state_q == ST_WAIT) && div_writeback_valid_i;
    assign timeout_hit = (state_q == ST_WAIT) && !div_writeback_valid_i
                         && (cnt_q == CNT_W'(WAIT_TIMEOUT - 1));
    assign killed      = kill_q || flush_i;

`ifdef DIV_ISSUE_DIVZERO_FAST_EN
    assign fast_zero = req_is_div && (req_rb_operand_i == '0);
`else
    assign fast_zero = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (req_is_div && !fast_zero) ? ST_ISSUE : ST_RESP;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (wb_done || timeout_hit) state_d = killed ? ST_IDLE : ST_RESP;
            ST_RESP:  if (flush_i || resp_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values (request latch, kill flag, watchdog, result)
    always_comb begin
        req_d        = req_q;
        value_d      = value_q;
        kill_d       = kill_q;
        cnt_d        = cnt_q;
        err_d        = 1'b0;
        ready_d      = (state_d == ST_IDLE);
        issue_d      = (state_d == ST_ISSUE);
        resp_valid_d = (state_d == ST_RESP);
        busy_d       = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                cnt_d  = '0;
                if (accept) begin
                    req_d = '{opcode:     req_opcode_i,
                              pc:         req_pc_i,
                              rd_idx:     req_rd_idx_i,
                              ra_idx:     req_ra_idx_i,
                              rb_idx:     req_rb_idx_i,
                              ra_operand: req_ra_operand_i,
                              rb_operand: req_rb_operand_i};
                    if (!req_is_div) value_d = '0;
`ifdef DIV_ISSUE_DIVZERO_FAST_EN
                    else if (fast_zero)
                        value_d = is_rem_op(req_opcode_i) ? req_ra_operand_i : '1;
`endif
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
                if (flush_i) kill_d = 1'b1;
            end
            ST_WAIT: begin
                if (flush_i) kill_d = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (wb_done) begin
                    value_d = div_writeback_value_i;
                end else if (timeout_hit) begin
                    value_d = '0;
                    err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            req_q        <= '0;
            value_q      <= '0;
            kill_q       <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            ready_q      <= 1'b1;
            issue_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            req_q        <= req_d;
            value_q      <= value_d;
            kill_q       <= kill_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            ready_q      <= ready_d;
            issue_q      <= issue_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Flush in IDLE blocks acceptance in the same cycle
    assign req_ready_o             = ready_q && !flush_i;
    assign div_opcode_valid_o      = issue_q;
    assign div_opcode_opcode_o     = req_q.opcode;
    assign div_opcode_pc_o         = req_q.pc;
    assign div_opcode_invalid_o    = 1'b0;
    assign div_opcode_rd_idx_o     = req_q.rd_idx;
    assign div_opcode_ra_idx_o     = req_q.ra_idx;
    assign div_opcode_rb_idx_o     = req_q.rb_idx;
    assign div_opcode_ra_operand_o = req_q.ra_operand;
    assign div_opcode_rb_operand_o = req_q.rb_operand;
    assign resp_valid_o            = resp_valid_q;
    assign resp_rd_idx_o           = req_q.rd_idx;
    assign resp_pc_o               = req_q.pc;
    assign resp_value_o            = value_q;
    assign busy_o                  = busy_q;
    assign busy_rd_idx_o           = req_q.rd_idx;
    assign err_timeout_o           = err_q;

endmodule
